rc_two_way_splitter: RTL and testbench
======================================

RC_TWO_WAY_SPLITTER -- requirements
Module: rc_two_way_splitter

Interface
REQ-001 The block SHALL have these parameters:
- R0, default 10000: branch-0 series resistance, ohms (longint).
- R1, default 10000: branch-1 series resistance, ohms (longint).
- C0_PF, default 2000: branch-0 load capacitance to ground, pF (longint); 0 means no capacitor.
- C1_PF, default 6000: branch-1 load capacitance to ground, pF (longint); 0 means no capacitor.
- SAMPLE_RATE, default 50000: audio_clk_en rate, Hz (longint).

REQ-002 The block SHALL have these ports:
- clk  in  1: system clock; sole clock.
- I_RST  in  1: reset, synchronous, active-high.
- audio_clk_en  in  1: sample strobe, one clk wide.
- in  in  16 signed: source voltage sample.
- out0  out  16 signed: branch-0 capacitor node voltage.
- out1  out  16 signed: branch-1 capacitor node voltage.
- out_valid  out  1: one-cycle pulse when out0/out1 update.
- busy  out  1: high while a sample is being processed.
- overrun  out  1: sticky; a strobe was dropped.

Function
REQ-003 Per branch i, the block SHALL use an elaboration-time coefficient ALPHA_i = (65536*10^12)/(10^12 + Ri*Ci_PF*SAMPLE_RATE), 17-bit unsigned, clamped to the range 1..65536; Ci_PF=0 SHALL give 65536.
REQ-004 Update rule per accepted sample SHALL be: y_i <= sat16(y_i + ((ALPHA_i * (x - y_i)) >>> 16)), with x - y_i computed at 17-bit signed width, the product at 35-bit signed width, an arithmetic (floor) shift, and saturation to -32768..32767.
REQ-005 The block SHALL contain exactly one shared signed multiplier, time-multiplexed between the two branches.
REQ-006 The FSM SHALL have the states IDLE, MUL0, ACC0, MUL1, ACC1, with one state per clk:
- IDLE: on audio_clk_en, latch x<=in and go to MUL0; otherwise stay in IDLE.
- MUL0: register prod<=ALPHA_0*(x-y0); go to ACC0.
- ACC0: y0 update; go to MUL1.
- MUL1: register prod<=ALPHA_1*(x-y1); go to ACC1.
- ACC1: y1 update; out0<=new y0, out1<=new y1, out_valid<=1; go to IDLE.
REQ-007 Latency SHALL be: strobe sampled at edge N means out0/out1/out_valid change at edge N+4, and out_valid is high for exactly one cycle.
REQ-008 out0 and out1 SHALL change only together, only at the ACC1 edge, and SHALL hold their value otherwise.
REQ-009 busy SHALL be 1 in MUL0, ACC0, MUL1 and ACC1, and 0 in IDLE.
REQ-010 An audio_clk_en seen while the FSM is not in IDLE, including in ACC1, SHALL be dropped and SHALL set overrun to 1. Minimum accepted strobe spacing is 5 clk.
REQ-011 overrun SHALL clear only on I_RST.
REQ-012 in SHALL be sampled only in IDLE on a strobe; changes to in mid-computation SHALL have no effect.
REQ-013 When ALPHA_i = 65536, y_i SHALL equal x exactly after the update (pass-through branch).

Reset
REQ-014 On I_RST high at a clk edge, the block SHALL set state=IDLE, x=0, y0=y1=0, prod=0, out0=out1=0, out_valid=0, busy=0, overrun=0.
REQ-015 Reset SHALL take priority over audio_clk_en in the same cycle; that strobe SHALL be dropped without setting overrun.
REQ-016 Reset asserted mid-computation SHALL abort the computation with no out_valid pulse; the next strobe after reset release SHALL be processed normally from y=0.

Verification (defaults: ALPHA_0=32768, ALPHA_1=16384)
REQ-017 Step: in=16000 with strobes every 8 clk -> out0 = 8000, 12000, 14000; out1 = 4000, 7000, 9250; each update arrives 4 clk after its strobe, with a single-cycle out_valid.
REQ-018 Negative step from reset: in=-16000, one strobe -> out0=-8000, out1=-4000.
REQ-019 Overrun: strobe at cycle 0 and again at cycle 2 -> one out_valid only, at cycle 4; overrun=1 from cycle 3 and still 1 after 100 further strobes spaced 10 clk; a strobe exactly at cycle 4 (ACC1) also sets overrun.
REQ-020 Reset mid-computation: strobe with in=16000, I_RST at cycle 2 -> no out_valid, out0=out1=0; a subsequent strobe with in=16000 -> out0=8000.
REQ-021 Pass-through and saturation: C0_PF=0 with in=32767, then -32768 -> out0 follows exactly; long run at in=32767 -> out1 converges monotonically and never exceeds 32767.

Source files
------------

// File: rtl/rc_two_way_splitter.sv
`default_nettype none
// ============================================================================
// Module      : rc_two_way_splitter
// Description : Two first-order RC low-pass branches fed from one source,
//               sharing a single time-multiplexed signed multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module rc_two_way_splitter #(
    parameter longint R0          = 10000,
    parameter longint R1          = 10000,
    parameter longint C0_PF       = 2000,
    parameter longint C1_PF       = 6000,
    parameter longint SAMPLE_RATE = 50000
) (
    input  logic               clk,
    input  logic               I_RST,
    input  logic               audio_clk_en,
    input  logic signed [15:0] in,
    output logic signed [15:0] out0,
    output logic signed [15:0] out1,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    function automatic longint calc_alpha(input longint r, input longint c, input longint sr);
        longint a;
        if (c == 0) begin
            a = 65536;
        end else begin
            a = (64'sd65536 * 64'sd1000000000000) / (64'sd1000000000000 + r * c * sr);
            if (a < 1)     a = 1;
            if (a > 65536) a = 65536;
        end
        return a;
    endfunction

    localparam logic [16:0] c_alpha0 = 17'(calc_alpha(R0, C0_PF, SAMPLE_RATE));
    localparam logic [16:0] c_alpha1 = 17'(calc_alpha(R1, C1_PF, SAMPLE_RATE));

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_MUL0 = 3'd1;
    localparam logic [2:0] c_ACC0 = 3'd2;
    localparam logic [2:0] c_MUL1 = 3'd3;
    localparam logic [2:0] c_ACC1 = 3'd4;

    logic        [2:0]  r_state;
    logic        [2:0]  w_next;
    logic signed [15:0] r_x;
    logic signed [15:0] r_y0;
    logic signed [15:0] r_y1;
    logic signed [18:0] r_prod;

    logic        [16:0] w_alpha;
    logic signed [15:0] w_y;
    logic signed [16:0] w_diff;
    logic signed [34:0] w_mult;
    logic signed [19:0] w_sum;
    logic signed [15:0] w_sat;

    // Branch select drives the one shared multiplier and the accumulator.
    assign w_alpha = (r_state == c_MUL1) ? c_alpha1 : c_alpha0;
    assign w_y     = (r_state == c_MUL1 || r_state == c_ACC1) ? r_y1 : r_y0;
    assign w_diff  = {r_x[15], r_x} - {w_y[15], w_y};
    assign w_mult  = $signed({{18{1'b0}}, w_alpha}) * $signed({{18{w_diff[16]}}, w_diff});
    assign w_sum   = {{4{w_y[15]}}, w_y} + {r_prod[18], r_prod};

    always_comb begin
        w_sat = w_sum[15:0];
        if (w_sum > 20'sd32767)
            w_sat = 16'sh7fff;
        else if (w_sum < -20'sd32768)
            w_sat = 16'sh8000;
    end

    assign busy = (r_state != c_IDLE);

    always_ff @(posedge clk) begin
        if (I_RST)
            r_state <= c_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (audio_clk_en) w_next = c_MUL0;
            c_MUL0:  w_next = c_ACC0;
            c_ACC0:  w_next = c_MUL1;
            c_MUL1:  w_next = c_ACC1;
            c_ACC1:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            r_x       <= '0;
            r_y0      <= '0;
            r_y1      <= '0;
            r_prod    <= '0;
            out0      <= '0;
            out1      <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (audio_clk_en && r_state != c_IDLE)
                overrun <= 1'b1;
            case (r_state)
                c_IDLE: if (audio_clk_en) r_x <= in;
                // Only the floor-shifted product is ever consumed.
                c_MUL0, c_MUL1: r_prod <= 19'(w_mult >>> 16);
                c_ACC0: r_y0 <= w_sat;
                c_ACC1: begin
                    r_y1      <= w_sat;
                    out0      <= r_y0;
                    out1      <= w_sat;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rc_two_way_splitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc_two_way_splitter
// Description : Table-driven and scoreboard checks for rc_two_way_splitter,
//               with a second pass-through (C0_PF=0) instance alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc_two_way_splitter;

    localparam longint c_E12 = 64'sd1000000000000;
    localparam longint c_A0  = (64'sd65536 * c_E12) / (c_E12 + 64'sd10000 * 64'sd2000 * 64'sd50000);
    localparam longint c_A1  = (64'sd65536 * c_E12) / (c_E12 + 64'sd10000 * 64'sd6000 * 64'sd50000);

    logic               clk = 1'b0;
    logic               I_RST = 1'b1;
    logic               audio_clk_en = 1'b0;
    logic signed [15:0] in_s = '0;
    logic signed [15:0] out0, out1, pt_out0, pt_out1;
    logic               out_valid, busy, overrun;
    logic               pt_valid, pt_busy, pt_overrun;

    rc_two_way_splitter u_dut (
        .clk(clk), .I_RST(I_RST), .audio_clk_en(audio_clk_en), .in(in_s),
        .out0(out0), .out1(out1), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    rc_two_way_splitter #(.C0_PF(0)) u_pt (
        .clk(clk), .I_RST(I_RST), .audio_clk_en(audio_clk_en), .in(in_s),
        .out0(pt_out0), .out1(pt_out1), .out_valid(pt_valid), .busy(pt_busy), .overrun(pt_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] e0;
        logic signed [15:0] e1;
        logic signed [15:0] x;
        int                 cyc;
    } sb_t;

    typedef struct {
        bit                 rst_first;
        logic signed [15:0] x;
        logic signed [15:0] e0;
        logic signed [15:0] e1;
    } vec_t;

    sb_t                q[$];
    int                 cyc = 0;
    int                 n_chk = 0;
    int                 n_pass = 0;
    logic signed [15:0] m0 = '0;
    logic signed [15:0] m1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic signed [15:0] upd(input logic signed [15:0] y,
                                               input logic signed [15:0] x,
                                               input longint a);
        longint s;
        s = longint'(y) + ((a * (longint'(x) - longint'(y))) >>> 16);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    // Scoreboard side: every out_valid must match the oldest pending sample.
    always @(negedge clk) begin
        if (out_valid || pt_valid) begin
            chk("pt_valid_align", pt_valid, out_valid);
            chk("valid_expected", (q.size() != 0), 1);
            if (q.size() != 0) begin
                sb_t e;
                e = q.pop_front();
                chk("out0", out0, e.e0);
                chk("out1", out1, e.e1);
                chk("pt_out0", pt_out0, e.x);
                chk("pt_out1", pt_out1, e.e1);
                chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        audio_clk_en = 1'b0;
        I_RST = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 I_RST = 1'b0;
        @(negedge clk);
        m0 = '0;
        m1 = '0;
    endtask

    // One-cycle strobe; input is scrambled afterwards to prove it is latched.
    task automatic pulse(input logic signed [15:0] x);
        audio_clk_en = 1'b1;
        in_s = x;
        @(posedge clk);
        #1 audio_clk_en = 1'b0;
        in_s = 16'($urandom);
        @(negedge clk);
    endtask

    task automatic accept(input logic signed [15:0] x, input logic signed [15:0] e0,
                          input logic signed [15:0] e1);
        sb_t e;
        e.e0 = e0; e.e1 = e1; e.x = x; e.cyc = cyc + 5;
        q.push_back(e);
        m0 = e0;
        m1 = e1;
        pulse(x);
    endtask

    task automatic accept_model(input logic signed [15:0] x);
        logic signed [15:0] n0;
        n0 = upd(m0, x, c_A0);
        accept(x, n0, upd(m1, x, c_A1));
    endtask

    vec_t vecs[4];

    initial begin
        logic signed [15:0] prev;
        vecs[0] = '{1'b1,  16'sd16000,  16'sd8000,  16'sd4000};
        vecs[1] = '{1'b0,  16'sd16000, 16'sd12000,  16'sd7000};
        vecs[2] = '{1'b0,  16'sd16000, 16'sd14000,  16'sd9250};
        vecs[3] = '{1'b1, -16'sd16000, -16'sd8000, -16'sd4000};

        do_reset();
        chk("rst_out0", out0, 0);
        chk("rst_out1", out1, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);

        // Reset and strobe in the same cycle: strobe lost, no overrun.
        I_RST = 1'b1;
        audio_clk_en = 1'b1;
        in_s = 16'sd16000;
        @(posedge clk);
        #1 I_RST = 1'b0;
        audio_clk_en = 1'b0;
        @(negedge clk);
        chk("rst_strobe_overrun", overrun, 0);
        chk("rst_strobe_busy", busy, 0);
        idle(6);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].rst_first) do_reset();
            accept(vecs[i].x, vecs[i].e0, vecs[i].e1);
            idle(7);
        end

        do_reset();
        accept_model(16'sd1000);
        chk("busy_mul0", busy, 1);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("busy_mid", busy, 1);
        end
        idle(1);
        chk("busy_idle", busy, 0);
        idle(4);

        do_reset();
        accept_model(16'sd16000);
        idle(1);
        chk("ovr_before", overrun, 0);
        pulse(16'sd1234);
        chk("ovr_set", overrun, 1);
        idle(8);
        for (int k = 0; k < 100; k++) begin
            accept_model(16'($urandom));
            idle(9);
        end
        chk("ovr_sticky", overrun, 1);

        do_reset();
        chk("ovr_cleared", overrun, 0);
        accept_model(-16'sd5000);
        idle(3);
        chk("ovr_pre_acc1", overrun, 0);
        pulse(16'sd777);
        chk("ovr_acc1", overrun, 1);
        idle(5);

        do_reset();
        pulse(16'sd16000);
        idle(1);
        I_RST = 1'b1;
        @(posedge clk);
        #1 I_RST = 1'b0;
        @(negedge clk);
        m0 = '0;
        m1 = '0;
        idle(6);
        chk("abort_out0", out0, 0);
        chk("abort_out1", out1, 0);
        accept(16'sd16000, 16'sd8000, 16'sd4000);
        idle(7);

        do_reset();
        accept_model(16'sd32767);
        idle(7);
        accept_model(-16'sd32768);
        idle(7);
        chk("pt_min", pt_out0, -32768);

        do_reset();
        prev = '0;
        for (int k = 0; k < 40; k++) begin
            accept_model(16'sd32767);
            idle(7);
            chk("out1_monotonic", (out1 >= prev), 1);
            prev = out1;
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("sb_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
